// File: rtl/elink_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// elink_pkg : emesh packet field layout and shared types for the etx path
// Revision  : 1.0
// ---------------------------------------------------------------------------
package elink_pkg;

   localparam int PKT_WRITE_BIT = 0;
   localparam int PKT_DM_LSB    = 1;
   localparam int PKT_DM_W      = 2;
   localparam int PKT_CM_LSB    = 3;
   localparam int PKT_CM_W      = 4;
   localparam int PKT_DA_LSB    = 8;
   localparam int PKT_DA_W      = 32;

   localparam logic [3:0] EGROUP_RR = 4'hE;
   localparam logic [1:0] DM_DOUBLE = 2'b11;

   typedef struct packed {
      logic rd;
      logic wr;
   } wait_t;

   // Field order mirrors packet bits [6:0] so a plain cast extracts it
   typedef struct packed {
      logic [PKT_CM_W-1:0] ctrlmode;
      logic [PKT_DM_W-1:0] datamode;
      logic                write;
   } pkt_ctrl_t;

   typedef struct packed {
      logic      valid;
      pkt_ctrl_t ctrl;
   } burst_ref_t;

   function automatic pkt_ctrl_t get_ctrl(input logic [6:0] lsb);
      return pkt_ctrl_t'(lsb);
   endfunction

endpackage
`default_nettype wire

// File: rtl/etx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// etx_fifo : flop-based synchronous FIFO, registered read pointer, DEPTH=2^n
// Revision : 1.0
// ---------------------------------------------------------------------------
module etx_fifo #(
   parameter int PW    = 104,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [PW-1:0]            din_i,
   output logic [PW-1:0]            dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int IW = $clog2(DEPTH);

   logic [PW-1:0] mem_q [DEPTH];
   logic [IW-1:0] wr_ptr_q, rd_ptr_q;
   logic [IW:0]   count_q;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (IW+1)'(DEPTH));
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule
`default_nettype wire

// File: rtl/etx_burst_protocol.sv
`default_nettype none
// ---------------------------------------------------------------------------
// etx_burst_protocol : elink tx stage - skid FIFO, ID filter, wait stall, burst
// Revision           : 1.0
// ---------------------------------------------------------------------------
module etx_burst_protocol
   import elink_pkg::*;
#(
   parameter int         PW        = 104,
   parameter int         AW        = 32,
   parameter logic [11:0] ID       = 12'h000,
   parameter logic [3:0] RRGROUP   = EGROUP_RR,
   parameter int         DEPTH     = 4,
   parameter int         BURST_MAX = 16,
   parameter int         STRIDE    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          etx_access,
   input  logic [PW-1:0] etx_packet,
   output logic          etx_rd_wait,
   output logic          etx_wr_wait,
   input  logic          tx_enable,
   output logic [PW-1:0] tx_packet,
   output logic          tx_access,
   output logic          tx_burst,
   input  logic          tx_io_wait,
   input  logic          tx_rd_wait,
   input  logic          tx_wr_wait,
   output logic [15:0]   drop_count,
   output logic          overflow
);

   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int BCW = $clog2(BURST_MAX) + 1;

   logic [AW-1:0]  etx_dst, head_dst;
   logic           accept, filtered, push_req, push, pop;
   logic           full, empty, blocked, burst_hit, near_full;
   logic [CW-1:0]  count;
   logic [PW-1:0]  head;
   pkt_ctrl_t      head_ctrl;

   wait_t          sync_q, etx_wait_q, etx_wait_d;
   logic [PW-1:0]  tx_packet_q, tx_packet_d;
   logic           tx_access_q, tx_access_d;
   logic           tx_burst_q, tx_burst_d;
   logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
   burst_ref_t     last_q, last_d;
   logic [AW-1:0]  last_dst_q, last_dst_d;
   logic [15:0]    drop_q, drop_d;
   logic           overflow_q, overflow_d;

   // Ingress: accept, local-ID filter (the RR group always passes), push
   assign etx_dst  = etx_packet[PKT_DA_LSB +: AW];
   assign accept   = etx_access & tx_enable;
   assign filtered = (etx_dst[AW-1 -: 12] == ID) & (etx_dst[AW-13 -: 4] != RRGROUP);
   assign push_req = accept & ~filtered;
   assign push     = push_req & (~full | pop);

   etx_fifo #(
      .PW    (PW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (etx_packet),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   assign head_ctrl = get_ctrl(head[6:0]);
   assign head_dst  = head[PKT_DA_LSB +: AW];
   assign blocked   = (head_ctrl.write & sync_q.wr) | (~head_ctrl.write & sync_q.rd);
   assign pop       = ~tx_io_wait & ~empty & ~blocked;
   assign near_full = (count >= CW'(DEPTH-1));

   assign burst_hit = tx_access_q
                    & head_ctrl.write
                    & (head_ctrl.datamode == DM_DOUBLE)
                    & last_q.valid
                    & (head_ctrl == last_q.ctrl)
                    & (head_dst == last_dst_q + AW'(STRIDE))
                    & (burst_cnt_q < BCW'(BURST_MAX-1));

   always_comb begin
      tx_packet_d = tx_packet_q;
      tx_access_d = tx_access_q;
      tx_burst_d  = tx_burst_q;
      burst_cnt_d = burst_cnt_q;
      last_d      = last_q;
      last_dst_d  = last_dst_q;
      drop_d      = drop_q;
      overflow_d  = overflow_q;

      etx_wait_d.wr = tx_wr_wait | tx_io_wait | near_full;
      etx_wait_d.rd = tx_rd_wait | tx_io_wait | near_full;

      if (accept & filtered & (drop_q != 16'hFFFF))
         drop_d = drop_q + 16'd1;
      if (push_req & full & ~pop)
         overflow_d = 1'b1;

      // Output registers freeze entirely while the IO stalls
      if (!tx_io_wait) begin
         if (pop) begin
            tx_packet_d  = head;
            tx_access_d  = 1'b1;
            tx_burst_d   = burst_hit;
            burst_cnt_d  = burst_hit ? burst_cnt_q + 1'b1 : '0;
            last_d.valid = 1'b1;
            last_d.ctrl  = head_ctrl;
            last_dst_d   = head_dst;
         end else begin
            tx_access_d = 1'b0;
            tx_burst_d  = 1'b0;
            burst_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '0;
         etx_wait_q  <= '0;
         tx_packet_q <= '0;
         tx_access_q <= 1'b0;
         tx_burst_q  <= 1'b0;
         burst_cnt_q <= '0;
         last_q      <= '0;
         last_dst_q  <= '0;
         drop_q      <= '0;
         overflow_q  <= 1'b0;
      end else begin
         sync_q.wr   <= tx_wr_wait;
         sync_q.rd   <= tx_rd_wait;
         etx_wait_q  <= etx_wait_d;
         tx_packet_q <= tx_packet_d;
         tx_access_q <= tx_access_d;
         tx_burst_q  <= tx_burst_d;
         burst_cnt_q <= burst_cnt_d;
         last_q      <= last_d;
         last_dst_q  <= last_dst_d;
         drop_q      <= drop_d;
         overflow_q  <= overflow_d;
      end
   end

   assign etx_wr_wait = etx_wait_q.wr;
   assign etx_rd_wait = etx_wait_q.rd;
   assign tx_packet   = tx_packet_q;
   assign tx_access   = tx_access_q;
   assign tx_burst    = tx_burst_q;
   assign drop_count  = drop_q;
   assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_etx_burst_protocol.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_etx_burst_protocol : scoreboard bench - directed scenarios plus random traffic
// Revision              : 1.0
// ---------------------------------------------------------------------------
module tb_etx_burst_protocol;

   localparam int PW        = 104;
   localparam int DEPTH     = 4;
   localparam int BURST_MAX = 16;
   localparam int STRIDE    = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          etx_access = 1'b0;
   logic [PW-1:0] etx_packet = '0;
   logic          etx_rd_wait, etx_wr_wait;
   logic          tx_enable = 1'b1;
   logic [PW-1:0] tx_packet;
   logic          tx_access, tx_burst;
   logic          tx_io_wait = 1'b0;
   logic          tx_rd_wait = 1'b0;
   logic          tx_wr_wait = 1'b0;
   logic [15:0]   drop_count;
   logic          overflow;

   etx_burst_protocol #(
      .PW(PW), .AW(32), .ID(12'h000), .RRGROUP(4'hE),
      .DEPTH(DEPTH), .BURST_MAX(BURST_MAX), .STRIDE(STRIDE)
   ) dut (
      .clk(clk), .reset(reset),
      .etx_access(etx_access), .etx_packet(etx_packet),
      .etx_rd_wait(etx_rd_wait), .etx_wr_wait(etx_wr_wait),
      .tx_enable(tx_enable), .tx_packet(tx_packet),
      .tx_access(tx_access), .tx_burst(tx_burst),
      .tx_io_wait(tx_io_wait), .tx_rd_wait(tx_rd_wait), .tx_wr_wait(tx_wr_wait),
      .drop_count(drop_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;
   int exp_drops = 0;
   logic [PW-1:0] exp_q[$];
   int obs_cyc[$];
   bit obs_burst[$];

   function automatic bit is_filtered(input logic [PW-1:0] p);
      return (p[39:28] == 12'h000) && (p[27:24] != 4'hE);
   endfunction

   function automatic logic [PW-1:0] dw(input logic [31:0] a);
      return {32'($urandom), 32'($urandom), a, 8'h07};
   endfunction
   function automatic logic [PW-1:0] sw(input logic [31:0] a);
      return {32'($urandom), 32'($urandom), a, 8'h05};
   endfunction
   function automatic logic [PW-1:0] rd(input logic [31:0] a);
      return {32'($urandom), 32'($urandom), a, 8'h04};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Reference: what the spec says the block does with a request
   task automatic send_model(input logic [PW-1:0] p);
      etx_access = 1'b1;
      etx_packet = p;
      if (tx_enable) begin
         if (is_filtered(p)) exp_drops++;
         else                exp_q.push_back(p);
      end
   endtask

   task automatic send_forced(input logic [PW-1:0] p, input bit delivered);
      etx_access = 1'b1;
      etx_packet = p;
      if (delivered) exp_q.push_back(p);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      etx_access = 1'b0;
   endtask

   task automatic drain(input string name, input int maxc);
      int n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         step();
         n++;
      end
      repeat (3) step();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_drain: %0d packets outstanding, required 0", name, exp_q.size());
      end
   endtask

   // Monitor: one transfer per output update (an update needs tx_io_wait=0 at the edge)
   bit          rst_seen = 1'b1;
   bit          iow_seen = 1'b0;
   bit          prev_acc = 1'b0;
   bit          have_last = 1'b0;
   int          run = 0;
   logic [PW-1:0] last_pkt = '0;

   always @(negedge clk) begin
      logic [PW-1:0] e;
      bit eb;
      if (rst_seen) begin
         prev_acc  = 1'b0;
         have_last = 1'b0;
         run       = 0;
      end else if (!iow_seen) begin
         if (tx_access) begin
            obs_cyc.push_back(cyc);
            obs_burst.push_back(tx_burst);
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_tx: got packet %h, required no packet", tx_packet);
            end else begin
               e  = exp_q.pop_front();
               eb = prev_acc && e[0] && (e[2:1] == 2'b11) && have_last &&
                    (e[6:0] == last_pkt[6:0]) &&
                    (e[39:8] == last_pkt[39:8] + 32'(STRIDE)) &&
                    (run < BURST_MAX-1);
               if (tx_packet !== e) begin
                  miscompares++;
                  $display("FAIL tx_packet: got %h, required %h", tx_packet, e);
               end
               vectors++;
               if (tx_burst !== eb) begin
                  miscompares++;
                  $display("FAIL tx_burst: got %b, required %b (dst %h)", tx_burst, eb, e[39:8]);
               end
               run       = eb ? run + 1 : 0;
               have_last = 1'b1;
               last_pkt  = e;
            end
         end else begin
            run = 0;
            vectors++;
            if (tx_burst !== 1'b0) begin
               miscompares++;
               $display("FAIL idle_burst: got %b, required 0", tx_burst);
            end
         end
         prev_acc = tx_access;
      end
      iow_seen = tx_io_wait;
      rst_seen = reset;
   end

   initial begin
      int t0;
      logic [31:0] next_addr;
      logic [PW-1:0] p;
      int r;

      repeat (3) step();
      chk("rst_tx_access", tx_access, 0);
      chk("rst_tx_packet", tx_packet, 0);
      chk("rst_waits", {etx_rd_wait, etx_wr_wait}, 0);
      chk("rst_drop_ovf", {drop_count, overflow}, 0);
      reset = 1'b0;
      step();

      // ID filter: group F dropped, RR group E transmitted
      obs_cyc.delete();
      send_model(dw(32'h000F_0000)); step(); idle();
      repeat (3) step();
      chk("t3_drop1", drop_count, 1);
      chk("t3_nothing_out", obs_cyc.size(), 0);
      send_model(dw(32'h000E_0000)); step(); idle();
      drain("t3", 20);
      chk("t3_drop_unchanged", drop_count, 1);
      chk("t3_rr_out", obs_cyc.size(), 1);

      // Eight back-to-back double writes: latency 2, burst 0,1,1,1,1,1,1,1
      obs_cyc.delete(); obs_burst.delete();
      t0 = cyc;
      for (int i = 0; i < 8; i++) begin
         send_model(dw(32'h8000_0000 + 32'(8*i)));
         step();
      end
      idle();
      drain("t1", 40);
      chk("t1_count", obs_cyc.size(), 8);
      if (obs_cyc.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_cycle%0d", i), obs_cyc[i] - t0, 2 + i);
            chk($sformatf("t1_burst%0d", i), obs_burst[i], (i != 0));
         end
      end

      // Twenty +8 double writes: burst breaks on transfers 1 and 17
      repeat (2) step();
      obs_cyc.delete(); obs_burst.delete();
      for (int i = 0; i < 20; i++) begin
         send_model(dw(32'h8100_0000 + 32'(8*i)));
         step();
      end
      idle();
      drain("t2", 40);
      chk("t2_count", obs_burst.size(), 20);
      if (obs_burst.size() == 20)
         for (int i = 0; i < 20; i++)
            chk($sformatf("t2_burst%0d", i), obs_burst[i], (i != 0 && i != 16));

      // Write blocked at head by remote wr wait; read behind it must not bypass
      obs_cyc.delete(); obs_burst.delete();
      tx_wr_wait = 1'b1;
      repeat (2) step();
      send_model(dw(32'h9000_0000)); step();
      send_model(rd(32'h9000_0100)); step();
      idle();
      repeat (5) step();
      chk("t5_blocked", obs_cyc.size(), 0);
      tx_wr_wait = 1'b0;
      t0 = cyc;
      drain("t5", 20);
      chk("t5_count", obs_cyc.size(), 2);
      if (obs_cyc.size() == 2) begin
         chk("t5_write_lat", obs_cyc[0] - t0, 2);
         chk("t5_read_lat", obs_cyc[1] - t0, 3);
         chk("t5_read_burst", obs_burst[1], 0);
      end

      // Random traffic from an upstream that honours pushback
      next_addr = 32'h8200_0000;
      for (int c = 0; c < 2000; c++) begin
         tx_io_wait = ($urandom_range(0, 9) == 0);
         tx_wr_wait = ($urandom_range(0, 7) == 0);
         tx_rd_wait = ($urandom_range(0, 7) == 0);
         tx_enable  = ($urandom_range(0, 15) != 0);
         idle();
         if ($urandom_range(0, 3) != 0) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
               p = dw(next_addr);
               next_addr = next_addr + 32'(STRIDE);
               if ($urandom_range(0, 49) == 0) next_addr = 32'hFFFF_FFF0;
            end else begin
               p = {32'($urandom), 32'($urandom), 32'($urandom), 1'b0, 7'($urandom)};
               if (r == 9) p[39:28] = 12'h000;
            end
            if ((p[0] && !etx_wr_wait) || (!p[0] && !etx_rd_wait))
               send_model(p);
         end
         step();
      end
      idle();
      tx_io_wait = 1'b0; tx_wr_wait = 1'b0; tx_rd_wait = 1'b0; tx_enable = 1'b1;
      drain("rand", 100);
      chk("rand_drop_count", drop_count, exp_drops);
      chk("rand_no_overflow", overflow, 0);

      // IO stall with an upstream that ignores pushback: 4 kept, 2 lost
      obs_cyc.delete();
      tx_io_wait = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         send_forced(sw(32'hA000_0000 + 32'(16*i)), i < DEPTH);
         step();
      end
      idle();
      step();
      chk("t4_wr_wait", etx_wr_wait, 1);
      chk("t4_overflow", overflow, 1);
      chk("t4_held", obs_cyc.size(), 0);
      tx_io_wait = 1'b0;
      drain("t4", 20);
      chk("t4_delivered", obs_cyc.size(), DEPTH);
      chk("t4_overflow_sticky", overflow, 1);

      // Reset with three entries queued and tx_access held high
      send_model(sw(32'hB000_0000)); step();
      send_model(sw(32'hB000_0010)); step();
      tx_io_wait = 1'b1;
      send_model(sw(32'hB000_0020)); step();
      send_model(sw(32'hB000_0030)); step();
      idle(); step();
      chk("t6_pre_access", tx_access, 1);
      reset = 1'b1; tx_io_wait = 1'b0;
      exp_q.delete();
      exp_drops = 0;
      step();
      chk("t6_access", tx_access, 0);
      chk("t6_drop", drop_count, 0);
      chk("t6_overflow", overflow, 0);
      chk("t6_waits", {etx_rd_wait, etx_wr_wait}, 0);
      reset = 1'b0;
      obs_cyc.delete();
      repeat (10) step();
      chk("t6_no_stale", obs_cyc.size(), 0);
      chk("t6_fifo_empty_wait", etx_wr_wait, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
